mem_dev_responder: RTL and testbench



---
 rtl/mem_dev_responder.sv | 188 ++++++++++++++++++
 tb/tb_mem_dev_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_dev_responder.sv
// DRAM-style device model on the mem_ctrl command bus: single open row, ACT/PRE/REFRESH timing,
// fixed-latency read return on DQ, and pulsed/counted protocol-violation reporting.
module mem_dev_responder #(
  parameter int unsigned ROW_W    = 4,
  parameter int unsigned COL_W    = 12,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned READ_LAT = 2,
  parameter int unsigned T_RCD    = 4,
  parameter int unsigned T_RP     = 2,
  parameter int unsigned T_RFC    = 5,
  parameter int unsigned T_REFI   = 340
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic [2:0]        command,
  input  logic [ROW_W-1:0]  RA,
  input  logic [COL_W-1:0]  CA,
  inout  wire logic [DATA_W-1:0] DQ,
  output logic              rd_drive,
  output logic              row_open,
  output logic [ROW_W-1:0]  open_row,
  output logic              cmd_err,
  output logic [7:0]        err_cnt,
  output logic              refresh_overdue
);

  localparam int unsigned ADDR_W = ROW_W + COL_W;
  localparam int unsigned T_MAX  = (T_RCD > T_RP) ? ((T_RCD > T_RFC) ? T_RCD : T_RFC)
                                                  : ((T_RP > T_RFC) ? T_RP : T_RFC);
  localparam int unsigned CNT_W  = $clog2(T_MAX + 1);
  localparam int unsigned REFI_W = $clog2(T_REFI + 1);

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_ACTIVATING   = 3'd1;
  localparam logic [2:0] ST_ACTIVE       = 3'd2;
  localparam logic [2:0] ST_PRECHARGING  = 3'd3;
  localparam logic [2:0] ST_REFRESHING   = 3'd4;

  localparam logic [2:0] CMD_NOP     = 3'b000;
  localparam logic [2:0] CMD_ACT     = 3'b001;
  localparam logic [2:0] CMD_READ    = 3'b010;
  localparam logic [2:0] CMD_WRITE   = 3'b011;
  localparam logic [2:0] CMD_PRE     = 3'b100;
  localparam logic [2:0] CMD_REFRESH = 3'b101;

  logic [2:0]        state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              row_open_nx;
  logic [ROW_W-1:0]  open_row_nx;
  logic [2:0]        cmd;
  logic              err, do_read, do_write, do_refresh;
  logic [REFI_W-1:0] refi_cnt;
  logic [ADDR_W-1:0] acc_addr;

  logic [DATA_W-1:0] mem [1 << ADDR_W];
  logic [READ_LAT-1:0] pipe_vld;
  logic [DATA_W-1:0]   pipe_dat [READ_LAT];

  // Deselected cycles and the 110/111 delay markers both behave as NOP.
  assign cmd      = (cs_n || command[2:1] == 2'b11) ? CMD_NOP : command;
  assign acc_addr = {open_row, CA};
  assign rd_drive = pipe_vld[READ_LAT-1];
  assign DQ       = rd_drive ? pipe_dat[READ_LAT-1] : 'z;

  // Countdowns leave their busy state on the edge that takes cnt from 1 to 0, so the
  // command sampled T_xx edges after the opening command is the first legal one.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    row_open_nx = row_open;
    open_row_nx = open_row;
    err         = 1'b0;
    do_read     = 1'b0;
    do_write    = 1'b0;
    do_refresh  = 1'b0;
    case (state)
      ST_IDLE: begin
        case (cmd)
          CMD_ACT: begin
            open_row_nx = RA;
            row_open_nx = 1'b1;
            if (T_RCD > 1) begin
              state_nx = ST_ACTIVATING;
              cnt_nx   = CNT_W'(T_RCD - 1);
            end else begin
              state_nx = ST_ACTIVE;
            end
          end
          CMD_REFRESH: begin
            do_refresh = 1'b1;
            if (T_RFC > 1) begin
              state_nx = ST_REFRESHING;
              cnt_nx   = CNT_W'(T_RFC - 1);
            end
          end
          CMD_READ, CMD_WRITE: err = 1'b1;
          default: ;
        endcase
      end
      ST_ACTIVATING: begin
        err    = (cmd != CMD_NOP);
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nx = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        case (cmd)
          CMD_READ: begin
            if (RA == open_row) do_read = 1'b1;
            else                err     = 1'b1;
          end
          CMD_WRITE: begin
            if (RA == open_row && !rd_drive) do_write = 1'b1;
            else                             err      = 1'b1;
          end
          CMD_PRE: begin
            row_open_nx = 1'b0;
            if (T_RP > 1) begin
              state_nx = ST_PRECHARGING;
              cnt_nx   = CNT_W'(T_RP - 1);
            end else begin
              state_nx = ST_IDLE;
            end
          end
          CMD_ACT, CMD_REFRESH: err = 1'b1;
          default: ;
        endcase
      end
      ST_PRECHARGING, ST_REFRESHING: begin
        err    = (cmd != CMD_NOP);
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      row_open <= 1'b0;
      open_row <= '0;
      cmd_err  <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      row_open <= row_open_nx;
      open_row <= open_row_nx;
      cmd_err  <= err;
      if (err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refi_cnt        <= '0;
      refresh_overdue <= 1'b0;
    end else if (do_refresh) begin
      refi_cnt        <= '0;
      refresh_overdue <= 1'b0;
    end else if (state != ST_REFRESHING && refi_cnt != REFI_W'(T_REFI)) begin
      refi_cnt <= refi_cnt + REFI_W'(1);
      if (refi_cnt == REFI_W'(T_REFI - 1)) refresh_overdue <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write && !rst) mem[acc_addr] <= DQ;
  end

  // Read data is captured at acceptance so an earlier WRITE is always visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
      for (int unsigned i = 0; i < READ_LAT; i++) pipe_dat[i] <= '0;
    end else begin
      pipe_vld[0] <= do_read;
      pipe_dat[0] <= mem[acc_addr];
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
    end
  end

endmodule

// File: tb/tb_mem_dev_responder.sv
// Directed bench for mem_dev_responder: timing windows, read streaming, bus conflict,
// refresh interval, chip select and reset abort, each checked against hand-derived values.
module tb_mem_dev_responder;

  localparam logic [2:0] NOP = 3'b000, ACT = 3'b001, RD = 3'b010, WR = 3'b011,
                         PRE = 3'b100, REF = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_n = 1'b0;
  logic [2:0]  command = NOP;
  logic [3:0]  ra = '0;
  logic [11:0] ca = '0;
  logic        dq_en = 1'b0;
  logic [31:0] dq_val = '0;
  wire  [31:0] dq;
  logic        rd_drive, row_open, cmd_err, refresh_overdue;
  logic [3:0]  open_row;
  logic [7:0]  err_cnt;

  int vectors = 0;
  int miscompares = 0;

  assign dq = dq_en ? dq_val : 'z;

  always #5 clk = ~clk;

  mem_dev_responder #(.ROW_W(4), .COL_W(12), .DATA_W(32), .READ_LAT(2), .T_RCD(4), .T_RP(2),
                      .T_RFC(5), .T_REFI(340)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .command(command), .RA(ra), .CA(ca), .DQ(dq),
    .rd_drive(rd_drive), .row_open(row_open), .open_row(open_row), .cmd_err(cmd_err),
    .err_cnt(err_cnt), .refresh_overdue(refresh_overdue)
  );

  // Present one command for the next edge, then sample 1 ns after it.
  task automatic step(input logic [2:0] c, input logic [3:0] r, input logic [11:0] a);
    command = c; ra = r; ca = a; cs_n = 1'b0; dq_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic step_wr(input logic [3:0] r, input logic [11:0] a, input logic [31:0] d);
    command = WR; ra = r; ca = a; cs_n = 1'b0; dq_en = 1'b1; dq_val = d;
    @(posedge clk); #1;
    dq_en = 1'b0;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(NOP, '0, '0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    nops(2);
    vectors++; if (rd_drive !== 1'b0) begin miscompares++; $display("FAIL reset_rd_drive: got %b want 0", rd_drive); end
    vectors++; if (row_open !== 1'b0) begin miscompares++; $display("FAIL reset_row_open: got %b want 0", row_open); end
    vectors++; if (open_row !== 4'd0) begin miscompares++; $display("FAIL reset_open_row: got %0d want 0", open_row); end
    vectors++; if (cmd_err !== 1'b0) begin miscompares++; $display("FAIL reset_cmd_err: got %b want 0", cmd_err); end
    vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    vectors++; if (refresh_overdue !== 1'b0) begin miscompares++; $display("FAIL reset_overdue: got %b want 0", refresh_overdue); end
    rst = 1'b0;
  endtask

  task automatic test_write_read;
    step(ACT, 4'd3, '0);
    vectors++; if (row_open !== 1'b1 || open_row !== 4'd3) begin miscompares++; $display("FAIL act_row: got open=%b row=%0d want 1/3", row_open, open_row); end
    nops(3);
    step_wr(4'd3, 12'h010, 32'hDEADBEEF);
    vectors++; if (cmd_err !== 1'b0) begin miscompares++; $display("FAIL wr_cmd_err: got %b want 0", cmd_err); end
    step(RD, 4'd3, 12'h010);
    vectors++; if (rd_drive !== 1'b0) begin miscompares++; $display("FAIL rd_lat_early: got %b want 0", rd_drive); end
    step(NOP, '0, '0);
    vectors++; if (rd_drive !== 1'b1 || dq !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_data: got drv=%b dq=%h want 1/deadbeef", rd_drive, dq); end
    step(NOP, '0, '0);
    vectors++; if (rd_drive !== 1'b0) begin miscompares++; $display("FAIL rd_one_cycle: got %b want 0", rd_drive); end
    vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL wr_rd_err_cnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_trcd;
    step(PRE, '0, '0);
    nops(1);
    step(ACT, 4'd2, '0);
    step(RD, 4'd2, '0);
    vectors++; if (cmd_err !== 1'b1 || err_cnt !== 8'd1) begin miscompares++; $display("FAIL trcd_err: got err=%b cnt=%0d want 1/1", cmd_err, err_cnt); end
    step(NOP, '0, '0);
    vectors++; if (cmd_err !== 1'b0 || rd_drive !== 1'b0) begin miscompares++; $display("FAIL trcd_no_drive1: got err=%b drv=%b want 0/0", cmd_err, rd_drive); end
    step(NOP, '0, '0);
    vectors++; if (rd_drive !== 1'b0) begin miscompares++; $display("FAIL trcd_no_drive2: got %b want 0", rd_drive); end
    step(RD, 4'd2, '0);
    vectors++; if (cmd_err !== 1'b0) begin miscompares++; $display("FAIL trcd_accept: got %b want 0", cmd_err); end
    step(NOP, '0, '0);
    vectors++; if (rd_drive !== 1'b1 || err_cnt !== 8'd1) begin miscompares++; $display("FAIL trcd_read_drv: got drv=%b cnt=%0d want 1/1", rd_drive, err_cnt); end
  endtask

  task automatic test_back_to_back;
    step(PRE, '0, '0);
    nops(1);
    step(ACT, 4'd5, '0);
    nops(3);
    step_wr(4'd5, 12'd1, 32'h11111111);
    step_wr(4'd5, 12'd2, 32'h22222222);
    step_wr(4'd5, 12'd3, 32'h33333333);
    step(RD, 4'd5, 12'd1);
    step(RD, 4'd5, 12'd2);
    vectors++; if (rd_drive !== 1'b1 || dq !== 32'h11111111) begin miscompares++; $display("FAIL b2b_word1: got drv=%b dq=%h want 1/11111111", rd_drive, dq); end
    step(RD, 4'd5, 12'd3);
    vectors++; if (rd_drive !== 1'b1 || dq !== 32'h22222222) begin miscompares++; $display("FAIL b2b_word2: got drv=%b dq=%h want 1/22222222", rd_drive, dq); end
    step(WR, 4'd5, 12'd1);
    vectors++; if (rd_drive !== 1'b1 || dq !== 32'h33333333) begin miscompares++; $display("FAIL b2b_word3: got drv=%b dq=%h want 1/33333333", rd_drive, dq); end
    vectors++; if (cmd_err !== 1'b1 || err_cnt !== 8'd2) begin miscompares++; $display("FAIL conflict_err: got err=%b cnt=%0d want 1/2", cmd_err, err_cnt); end
    step(NOP, '0, '0);
    vectors++; if (cmd_err !== 1'b0 || rd_drive !== 1'b0) begin miscompares++; $display("FAIL conflict_pulse: got err=%b drv=%b want 0/0", cmd_err, rd_drive); end
    step(RD, 4'd5, 12'd1);
    step(NOP, '0, '0);
    vectors++; if (dq !== 32'h11111111) begin miscompares++; $display("FAIL conflict_dropped: got %h want 11111111", dq); end
  endtask

  task automatic test_pre_act;
    step(PRE, '0, '0);
    nops(1);
    step(ACT, 4'd1, '0);
    nops(3);
    step(PRE, '0, '0);
    vectors++; if (row_open !== 1'b0) begin miscompares++; $display("FAIL pre_row_open: got %b want 0", row_open); end
    step(ACT, 4'd7, '0);
    vectors++; if (cmd_err !== 1'b1 || err_cnt !== 8'd3) begin miscompares++; $display("FAIL trp_err: got err=%b cnt=%0d want 1/3", cmd_err, err_cnt); end
    step(ACT, 4'd7, '0);
    vectors++; if (cmd_err !== 1'b0 || row_open !== 1'b1 || open_row !== 4'd7) begin miscompares++; $display("FAIL trp_accept: got err=%b open=%b row=%0d want 0/1/7", cmd_err, row_open, open_row); end
  endtask

  task automatic test_refresh;
    rst = 1'b1;
    step(NOP, '0, '0);
    rst = 1'b0;
    nops(339);
    vectors++; if (refresh_overdue !== 1'b0) begin miscompares++; $display("FAIL refi_early: got %b want 0", refresh_overdue); end
    step(NOP, '0, '0);
    vectors++; if (refresh_overdue !== 1'b1) begin miscompares++; $display("FAIL refi_overdue: got %b want 1", refresh_overdue); end
    nops(5);
    vectors++; if (refresh_overdue !== 1'b1) begin miscompares++; $display("FAIL refi_sticky: got %b want 1", refresh_overdue); end
    step(REF, '0, '0);
    vectors++; if (refresh_overdue !== 1'b0 || cmd_err !== 1'b0) begin miscompares++; $display("FAIL refresh_clear: got ovd=%b err=%b want 0/0", refresh_overdue, cmd_err); end
    nops(4);
    step(ACT, 4'd9, '0);
    vectors++; if (cmd_err !== 1'b0 || row_open !== 1'b1 || open_row !== 4'd9) begin miscompares++; $display("FAIL trfc_accept: got err=%b open=%b row=%0d want 0/1/9", cmd_err, row_open, open_row); end
    vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL refresh_err_cnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_cs_n;
    nops(3);
    command = ACT; ra = 4'd2; cs_n = 1'b1;
    @(posedge clk); #1;
    vectors++; if (cmd_err !== 1'b0 || open_row !== 4'd9) begin miscompares++; $display("FAIL csn_active: got err=%b row=%0d want 0/9", cmd_err, open_row); end
    step(PRE, '0, '0);
    nops(1);
    command = ACT; ra = 4'd4; cs_n = 1'b1;
    @(posedge clk); #1;
    vectors++; if (row_open !== 1'b0 || cmd_err !== 1'b0) begin miscompares++; $display("FAIL csn_idle: got open=%b err=%b want 0/0", row_open, cmd_err); end
    step(3'b110, '0, '0);
    step(3'b111, '0, '0);
    vectors++; if (cmd_err !== 1'b0 || err_cnt !== 8'd0 || row_open !== 1'b0) begin miscompares++; $display("FAIL delay_marker: got err=%b cnt=%0d open=%b want 0/0/0", cmd_err, err_cnt, row_open); end
  endtask

  task automatic test_reset_mid_read;
    step(ACT, 4'd4, '0);
    nops(3);
    step_wr(4'd4, 12'h020, 32'hCAFEF00D);
    step(RD, 4'd4, 12'h020);
    rst = 1'b1;
    step(NOP, '0, '0);
    vectors++; if (rd_drive !== 1'b0) begin miscompares++; $display("FAIL rst_abort1: got %b want 0", rd_drive); end
    rst = 1'b0;
    step(NOP, '0, '0);
    vectors++; if (rd_drive !== 1'b0 || err_cnt !== 8'd0 || row_open !== 1'b0) begin miscompares++; $display("FAIL rst_abort2: got drv=%b cnt=%0d open=%b want 0/0/0", rd_drive, err_cnt, row_open); end
    step(ACT, 4'd4, '0);
    nops(3);
    step(RD, 4'd4, 12'h020);
    step(NOP, '0, '0);
    vectors++; if (rd_drive !== 1'b1 || dq !== 32'hCAFEF00D) begin miscompares++; $display("FAIL rst_keeps_mem: got drv=%b dq=%h want 1/cafef00d", rd_drive, dq); end
  endtask

  task automatic test_err_saturate;
    for (int i = 0; i < 254; i++) step(ACT, 4'd1, '0);
    vectors++; if (err_cnt !== 8'd254) begin miscompares++; $display("FAIL err_cnt_254: got %0d want 254", err_cnt); end
    step(ACT, 4'd1, '0);
    step(REF, '0, '0);
    vectors++; if (err_cnt !== 8'd255 || cmd_err !== 1'b1 || open_row !== 4'd4) begin miscompares++; $display("FAIL err_cnt_sat: got cnt=%0d err=%b row=%0d want 255/1/4", err_cnt, cmd_err, open_row); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_write_read;
    test_trcd;
    test_back_to_back;
    test_pre_act;
    test_refresh;
    test_cs_n;
    test_reset_mid_read;
    test_err_saturate;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
